// File: rtl/gshare_bht.sv
// Gshare branch history table: PC-xor-history indexed 2-D counter table with
// zero-latency multi-slot prediction, saturating updates, and a row-by-row clear FSM.
module gshare_bht #(
   parameter int unsigned  NR_ENTRIES      = 1024,
   parameter int unsigned  INSTR_PER_FETCH = 2,
   parameter int unsigned  CTR_BITS        = 2,
   parameter int unsigned  GHR_BITS        = 8,
   parameter int unsigned  VLEN            = 32,
   localparam int unsigned NR_ROWS         = NR_ENTRIES / INSTR_PER_FETCH,
   localparam int unsigned ROW_BITS        = $clog2(NR_ROWS),
   localparam int unsigned COL_BITS        = $clog2(INSTR_PER_FETCH)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_bp_i,
   input  logic                       debug_mode_i,
   input  logic [VLEN-1:0]            vpc_i,
   input  logic                       update_valid_i,
   input  logic [VLEN-1:0]            update_pc_i,
   input  logic                       update_taken_i,
   input  logic [ROW_BITS-1:0]        update_row_i,
   input  logic                       ghr_shift_i,
   input  logic                       ghr_shift_taken_i,
   input  logic                       ghr_restore_i,
   input  logic [GHR_BITS-1:0]        ghr_restore_val_i,
   output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
   output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
   output logic [ROW_BITS-1:0]        pred_row_o,
   output logic [GHR_BITS-1:0]        ghr_o,
   output logic                       busy_o
);

   localparam int unsigned         OFFSET  = 1;
   localparam int unsigned         COL_W   = (COL_BITS == 0) ? 1 : COL_BITS;
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NR_ROWS - 1);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_e;

   state_e              r_state;
   state_e              w_state_nxt;
   logic [ROW_BITS-1:0] r_clr_cnt;
   logic [ROW_BITS-1:0] w_clr_cnt_nxt;
   logic [GHR_BITS-1:0] r_ghr;
   logic [GHR_BITS-1:0] w_ghr_nxt;
   logic [GHR_BITS-1:0] w_ghr_shifted;
   logic [ROW_BITS-1:0] w_hist;
   logic [ROW_BITS-1:0] w_row;
   logic                w_busy;
   logic                w_upd_en;
   logic [COL_W-1:0]    w_upd_col;
   logic [CTR_BITS-1:0] w_upd_old;
   logic [CTR_BITS-1:0] w_upd_new;

   logic [CTR_BITS-1:0] r_table [NR_ROWS][INSTR_PER_FETCH];

   // History is zero-extended or truncated to the row index width.
   generate
      if (GHR_BITS >= ROW_BITS) begin : g_hist_trunc
         assign w_hist = r_ghr[ROW_BITS-1:0];
      end else begin : g_hist_ext
         assign w_hist = {{(ROW_BITS-GHR_BITS){1'b0}}, r_ghr};
      end

      if (GHR_BITS == 1) begin : g_shift_one
         assign w_ghr_shifted = ghr_shift_taken_i;
      end else begin : g_shift_multi
         assign w_ghr_shifted = {r_ghr[GHR_BITS-2:0], ghr_shift_taken_i};
      end

      if (COL_BITS == 0) begin : g_col_none
         assign w_upd_col = '0;
      end else begin : g_col_sel
         assign w_upd_col = update_pc_i[OFFSET +: COL_W];
      end
   endgenerate

   assign w_busy     = (r_state == ST_CLEAR);
   assign busy_o     = w_busy;
   assign ghr_o      = r_ghr;
   assign w_row      = vpc_i[OFFSET+COL_BITS +: ROW_BITS] ^ w_hist;
   assign pred_row_o = w_row;
   assign pred_valid_o = w_busy ? '0 : '1;

   generate
      for (genvar g = 0; g < INSTR_PER_FETCH; g++) begin : g_pred
         assign pred_taken_o[g] = r_table[w_row][g][CTR_BITS-1];
      end
   endgenerate

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      case (r_state)
         ST_IDLE: begin
            if (flush_bp_i) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_cnt_nxt = '0;
            end
         end
         ST_CLEAR: begin
            if (flush_bp_i) begin
               w_clr_cnt_nxt = '0;
            end else if (r_clr_cnt == LAST_ROW) begin
               w_state_nxt   = ST_IDLE;
               w_clr_cnt_nxt = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt   = ST_CLEAR;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_ghr_nxt = r_ghr;
      if (flush_bp_i) begin
         w_ghr_nxt = '0;
      end else if (ghr_restore_i) begin
         w_ghr_nxt = ghr_restore_val_i;
      end else if (ghr_shift_i) begin
         w_ghr_nxt = w_ghr_shifted;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
         r_ghr     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_cnt <= w_clr_cnt_nxt;
         r_ghr     <= w_ghr_nxt;
      end
   end

   always_comb begin
      w_upd_en  = update_valid_i && !debug_mode_i && !w_busy;
      w_upd_old = r_table[update_row_i][w_upd_col];
      w_upd_new = w_upd_old;
      if (update_taken_i) begin
         if (w_upd_old != CTR_MAX) w_upd_new = w_upd_old + 1'b1;
      end else begin
         if (w_upd_old != '0) w_upd_new = w_upd_old - 1'b1;
      end
   end

   // Updates are gated off while clearing, so the clear write always wins a collision.
   always_ff @(posedge clk_i) begin
      if (w_busy) begin
         for (int unsigned c = 0; c < INSTR_PER_FETCH; c++) begin
            r_table[r_clr_cnt][COL_W'(c)] <= CTR_WNT;
         end
      end else if (w_upd_en) begin
         r_table[update_row_i][w_upd_col] <= w_upd_new;
      end
   end

endmodule

// File: tb/tb_gshare_bht.sv
// Randomized self-checking bench for gshare_bht against an abstract table/history model.
module tb_gshare_bht;

   localparam int NR_ROWS  = 512;
   localparam int IPF      = 2;
   localparam int ROW_BITS = 9;
   localparam int GHR_BITS = 8;
   localparam int VLEN     = 32;

   logic                clk;
   logic                rst;
   logic                flush_bp;
   logic                debug_mode;
   logic [VLEN-1:0]     vpc;
   logic                update_valid;
   logic [VLEN-1:0]     update_pc;
   logic                update_taken;
   logic [ROW_BITS-1:0] update_row;
   logic                ghr_shift;
   logic                ghr_shift_taken;
   logic                ghr_restore;
   logic [GHR_BITS-1:0] ghr_restore_val;
   logic [IPF-1:0]      pred_valid;
   logic [IPF-1:0]      pred_taken;
   logic [ROW_BITS-1:0] pred_row;
   logic [GHR_BITS-1:0] ghr;
   logic                busy;

   gshare_bht #(
      .NR_ENTRIES      (1024),
      .INSTR_PER_FETCH (IPF),
      .CTR_BITS        (2),
      .GHR_BITS        (GHR_BITS),
      .VLEN            (VLEN)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .flush_bp_i        (flush_bp),
      .debug_mode_i      (debug_mode),
      .vpc_i             (vpc),
      .update_valid_i    (update_valid),
      .update_pc_i       (update_pc),
      .update_taken_i    (update_taken),
      .update_row_i      (update_row),
      .ghr_shift_i       (ghr_shift),
      .ghr_shift_taken_i (ghr_shift_taken),
      .ghr_restore_i     (ghr_restore),
      .ghr_restore_val_i (ghr_restore_val),
      .pred_valid_o      (pred_valid),
      .pred_taken_o      (pred_taken),
      .pred_row_o        (pred_row),
      .ghr_o             (ghr),
      .busy_o            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Abstract model: a flush/reset makes every counter weakly-not-taken at once and
   // then just counts NR_ROWS busy cycles; predictions are invisible while busy anyway.
   int unsigned m_ctr [NR_ROWS][IPF];
   int unsigned m_ghr;
   int          m_busy_left;

   function automatic void m_fill();
      for (int r = 0; r < NR_ROWS; r++)
         for (int c = 0; c < IPF; c++)
            m_ctr[r][c] = 1;
   endfunction

   function automatic void model_reset();
      m_fill();
      m_ghr       = 0;
      m_busy_left = NR_ROWS;
   endfunction

   function automatic int unsigned m_row(input logic [VLEN-1:0] pc);
      return ((pc >> 2) % NR_ROWS) ^ m_ghr;
   endfunction

   task automatic check_outputs();
      int unsigned row;
      row = m_row(vpc);
      check("busy", busy, m_busy_left > 0);
      check("pred_valid", pred_valid, (m_busy_left > 0) ? 0 : 3);
      check("ghr", ghr, m_ghr);
      check("pred_row", pred_row, row);
      if (m_busy_left == 0)
         for (int i = 0; i < IPF; i++)
            check("pred_taken", pred_taken[i], m_ctr[row][i] >= 2);
   endtask

   function automatic void model_advance();
      int unsigned col;
      if (rst) begin
         model_reset();
         return;
      end
      if (update_valid && !debug_mode && m_busy_left == 0) begin
         col = (update_pc >> 1) % IPF;
         if (update_taken) begin
            if (m_ctr[update_row][col] < 3) m_ctr[update_row][col]++;
         end else begin
            if (m_ctr[update_row][col] > 0) m_ctr[update_row][col]--;
         end
      end
      if (flush_bp)          m_ghr = 0;
      else if (ghr_restore)  m_ghr = ghr_restore_val;
      else if (ghr_shift)    m_ghr = ((m_ghr << 1) | ghr_shift_taken) % 256;
      if (flush_bp) begin
         m_fill();
         m_busy_left = NR_ROWS;
      end else if (m_busy_left > 0) begin
         m_busy_left--;
      end
   endfunction

   task automatic step();
      @(negedge clk);
      check_outputs();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      flush_bp = 0; debug_mode = 0; update_valid = 0; update_taken = 0;
      ghr_shift = 0; ghr_shift_taken = 0; ghr_restore = 0;
   endtask

   task automatic wait_clear(input string tag, input int exp_len);
      int n;
      n = 0;
      while (busy && n < 600) begin
         step();
         n++;
      end
      check(tag, n, exp_len);
   endtask

   task automatic upd(input int row, input logic [VLEN-1:0] pc, input logic tk, input int times);
      update_valid = 1; update_row = row[ROW_BITS-1:0]; update_pc = pc; update_taken = tk;
      repeat (times) step();
      update_valid = 0;
   endtask

   task automatic async_reset();
      rst = 1;
      model_reset();
      #1;
      check("rst_busy", busy, 1);
      check("rst_ghr", ghr, 0);
      check("rst_valid", pred_valid, 0);
      repeat (2) step();
      rst = 0;
   endtask

   initial begin
      rst = 1; quiet(); vpc = 0; update_pc = 0; update_row = 0; ghr_restore_val = 0;
      model_reset();
      repeat (3) step();
      rst = 0;
      wait_clear("reset_busy_len", NR_ROWS);
      for (int i = 0; i < 4; i++) begin
         vpc = $urandom;
         step();
         check("post_reset_valid", pred_valid, 2'b11);
         check("post_reset_taken", pred_taken, 2'b00);
      end

      // Saturating counter on row 5, column 0 (ghr is 0 here)
      vpc = 32'h14;
      upd(5, 0, 1, 2);
      step();
      check("r5_taken_2x", pred_taken[0], 1);
      upd(5, 0, 0, 3);
      step();
      check("r5_nt_3x", pred_taken[0], 0);
      upd(5, 0, 0, 1);
      upd(5, 0, 1, 2);
      step();
      check("r5_sat_low", pred_taken[0], 1);
      upd(5, 0, 1, 3);
      upd(5, 0, 0, 1);
      step();
      check("r5_sat_high", pred_taken[0], 1);
      upd(5, 0, 0, 1);
      step();
      check("r5_down_to_1", pred_taken[0], 0);
      check("r5_col1", pred_taken[1], 0);

      // History shift / restore
      ghr_shift = 1;
      ghr_shift_taken = 1; step();
      ghr_shift_taken = 0; step();
      ghr_shift_taken = 1; step();
      ghr_shift = 0;
      check("ghr_101", ghr, 8'h05);
      vpc = 0;
      step();
      check("row_from_ghr", pred_row, 9'h005);
      ghr_restore = 1; ghr_restore_val = 8'hA0; ghr_shift = 1; ghr_shift_taken = 1;
      step();
      quiet();
      check("ghr_restore_wins", ghr, 8'hA0);
      ghr_restore = 1; ghr_restore_val = 0; step(); ghr_restore = 0;

      // Debug mode suppresses updates
      debug_mode = 1;
      upd(5, 0, 1, 3);
      upd(5, 2, 1, 3);
      debug_mode = 0;
      vpc = 32'h14;
      step();
      check("debug_no_update", pred_taken, 2'b00);

      // Flush from IDLE, updates while busy, re-flush at clear cycle 100
      ghr_shift = 1; ghr_shift_taken = 1; step(); ghr_shift = 0;
      flush_bp = 1; step(); flush_bp = 0;
      check("flush_ghr", ghr, 0);
      check("flush_busy", busy, 1);
      for (int n = 1; n < 100; n++) begin
         update_valid = (n >= 10 && n < 14); update_row = 5; update_pc = 0; update_taken = 1;
         ghr_shift = (n == 50); ghr_shift_taken = 1;
         step();
      end
      quiet();
      flush_bp = 1; step(); flush_bp = 0;
      check("reflush_ghr", ghr, 0);
      wait_clear("reflush_busy_len", NR_ROWS);
      vpc = 32'h14;
      step();
      check("busy_update_dropped", pred_taken, 2'b00);

      // Randomized traffic, with one asynchronous reset in the middle
      for (int n = 0; n < 4000; n++) begin
         int unsigned hot;
         if (n == 2000) begin
            async_reset();
         end
         hot = $urandom % 8;
         vpc = ($urandom % 2) ? $urandom : ((((hot ^ m_ghr) % NR_ROWS) << 2) | ($urandom % 4));
         update_valid = ($urandom % 3) == 0;
         update_pc = $urandom;
         update_taken = $urandom % 2;
         update_row = ($urandom % 2) ? ROW_BITS'($urandom % 8) : ROW_BITS'($urandom);
         debug_mode = ($urandom % 10) == 0;
         ghr_shift = $urandom % 2;
         ghr_shift_taken = $urandom % 2;
         ghr_restore = ($urandom % 16) == 0;
         ghr_restore_val = GHR_BITS'($urandom);
         flush_bp = ($urandom % 700) == 0;
         step();
      end
      quiet();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
